// File: rtl/osc_meas_bank.sv
// rtl/osc_meas_bank.sv - ring-oscillator frequency measurement bank
// Counts synchronised rising edges of one channel, or of all channels in turn, over a window of clock cycles.
module osc_meas_bank #(
  parameter int NUM_CHANNELS = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int COUNT_WIDTH  = 32,
  parameter int WINDOW_WIDTH = 24
) (
  input  logic                    CLOCK,
  input  logic                    RESET_N,
  input  logic [NUM_CHANNELS-1:0] OSC_IN,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic                    MODE,
  input  logic [ADDR_WIDTH-1:0]   CHANNEL,
  input  logic [WINDOW_WIDTH-1:0] WINDOW_CYCLES,
  input  logic [ADDR_WIDTH-1:0]   RD_ADDR,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERROR,
  output logic [NUM_CHANNELS-1:0] VALID,
  output logic [NUM_CHANNELS-1:0] OVF,
  output logic [COUNT_WIDTH-1:0]  RD_COUNT
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_STORE} state_t;

  state_t                  state, state_nxt;
  logic [NUM_CHANNELS-1:0] sync1, sync2;
  logic                    prev;
  logic                    mode_q;
  logic [ADDR_WIDTH-1:0]   cur_ch;
  logic [WINDOW_WIDTH-1:0] win, timer;
  logic [COUNT_WIDTH-1:0]  count;
  logic [COUNT_WIDTH-1:0]  result [NUM_CHANNELS];

  logic [IDX_W-1:0] ch_idx, rd_idx;
  logic             sel, edge_det, chan_ok, start_req, last_ch;

  assign ch_idx    = cur_ch[IDX_W-1:0];
  assign rd_idx    = RD_ADDR[IDX_W-1:0];
  assign sel       = sync2[ch_idx];
  assign edge_det  = sel & ~prev;
  assign chan_ok   = int'(CHANNEL) < NUM_CHANNELS;
  // ABORT takes priority over START when both arrive in IDLE
  assign start_req = (state == S_IDLE) && START && !ABORT;
  assign last_ch   = !mode_q || (int'(cur_ch) == NUM_CHANNELS - 1);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = (state != S_IDLE);
    case (state)
      S_IDLE:    if (start_req && (MODE || chan_ok)) state_nxt = S_ARM;
      S_ARM:     state_nxt = S_MEASURE;
      S_MEASURE: if (timer == WINDOW_WIDTH'(1)) state_nxt = S_STORE;
      S_STORE:   state_nxt = last_ch ? S_IDLE : S_ARM;
      default:   state_nxt = S_IDLE;
    endcase
    if (ABORT && state != S_IDLE) state_nxt = S_IDLE;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= 1'b0;
      mode_q   <= 1'b0;
      cur_ch   <= '0;
      win      <= '0;
      timer    <= '0;
      count    <= '0;
      DONE     <= 1'b0;
      ERROR    <= 1'b0;
      VALID    <= '0;
      OVF      <= '0;
      RD_COUNT <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) result[i] <= '0;
    end else begin
      sync1 <= OSC_IN;
      sync2 <= sync1;
      prev  <= sel;
      DONE  <= 1'b0;
      if (int'(RD_ADDR) < NUM_CHANNELS) RD_COUNT <= result[rd_idx];
      else                              RD_COUNT <= '0;

      case (state)
        S_IDLE: begin
          if (start_req) begin
            mode_q <= MODE;
            win    <= (WINDOW_CYCLES == '0) ? WINDOW_WIDTH'(1) : WINDOW_CYCLES;
            cur_ch <= MODE ? '0 : CHANNEL;
            ERROR  <= !MODE && !chan_ok;
            DONE   <= !MODE && !chan_ok;
          end
        end
        S_ARM: begin
          count          <= '0;
          timer          <= win;
          VALID[ch_idx]  <= 1'b0;
          OVF[ch_idx]    <= 1'b0;
        end
        S_MEASURE: begin
          timer <= timer - WINDOW_WIDTH'(1);
          if (edge_det) begin
            if (count == '1) OVF[ch_idx] <= 1'b1;
            else             count <= count + COUNT_WIDTH'(1);
          end
        end
        S_STORE: begin
          // an abort landing on the store cycle leaves this slot invalid
          if (!ABORT) begin
            result[ch_idx] <= count;
            VALID[ch_idx]  <= 1'b1;
            if (last_ch) DONE   <= 1'b1;
            else         cur_ch <= cur_ch + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_meas_bank.sv
// tb/tb_osc_meas_bank.sv - scoreboard bench for osc_meas_bank
// Stimulus pushes expected DONE records and read values; a negedge monitor pops and compares.
module tb_osc_meas_bank;

  localparam int NCH = 4;
  localparam int AW  = 4;
  localparam int CW  = 5;
  localparam int WW  = 8;

  logic            CLOCK = 1'b0;
  logic            RESET_N = 1'b0;
  logic [NCH-1:0]  OSC_IN;
  logic            START = 1'b0;
  logic            ABORT = 1'b0;
  logic            MODE = 1'b0;
  logic [AW-1:0]   CHANNEL = '0;
  logic [WW-1:0]   WINDOW_CYCLES = '0;
  logic [AW-1:0]   RD_ADDR = '0;
  logic            BUSY, DONE, ERROR;
  logic [NCH-1:0]  VALID, OVF;
  logic [CW-1:0]   RD_COUNT;

  osc_meas_bank #(
    .NUM_CHANNELS(NCH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .WINDOW_WIDTH(WW)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .OSC_IN(OSC_IN), .START(START), .ABORT(ABORT),
    .MODE(MODE), .CHANNEL(CHANNEL), .WINDOW_CYCLES(WINDOW_CYCLES), .RD_ADDR(RD_ADDR),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .VALID(VALID), .OVF(OVF), .RD_COUNT(RD_COUNT)
  );

  typedef struct {
    int             cyc;
    logic           err;
    logic [NCH-1:0] valid;
    logic [NCH-1:0] ovf;
  } done_t;

  done_t          doneq[$];
  int             rdq[$];
  int             tests = 0;
  int             fails = 0;
  int             cyc = 0;
  int             ph = 0;
  int             per [NCH] = '{0, 0, 0, 0};
  logic [NCH-1:0] manual = '0;
  logic [NCH-1:0] gen = '0;
  logic           rd_strobe = 1'b0;
  logic           rd_seen = 1'b0;
  done_t          exp_d;
  int             c0;

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) begin
    cyc     <= cyc + 1;
    rd_seen <= rd_strobe;
  end

  // per[i] == 0 means the channel follows manual[i]; otherwise a square wave of per[i] clocks
  always @(negedge CLOCK) begin
    ph = ph + 1;
    for (int i = 0; i < NCH; i++)
      gen[i] = (per[i] != 0) && ((ph % per[i]) < per[i] / 2);
  end

  always_comb begin
    OSC_IN = '0;
    for (int i = 0; i < NCH; i++) OSC_IN[i] = (per[i] == 0) ? manual[i] : gen[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(negedge CLOCK) begin
    if (RESET_N) begin
      if (DONE) begin
        if (doneq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          exp_d = doneq.pop_front();
          check("done_cycle", cyc, exp_d.cyc);
          check("done_error", ERROR, exp_d.err);
          check("done_valid", VALID, exp_d.valid);
          check("done_ovf", OVF, exp_d.ovf);
          check("done_busy", BUSY, 0);
        end
      end
      if (rd_seen) begin
        if (rdq.size() == 0) check("unexpected_read", 1, 0);
        else                 check("rd_count", RD_COUNT, rdq.pop_front());
      end
    end
  end

  // cycle 0 is the cycle in which START is high; returns in cycle 1
  task automatic start_run(input logic m, input int ch, input int w);
    MODE = m; CHANNEL = AW'(ch); WINDOW_CYCLES = WW'(w); START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
  endtask

  task automatic expect_done(input int k, input logic err, input logic [NCH-1:0] v, input logic [NCH-1:0] o);
    doneq.push_back('{cyc + k, err, v, o});
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (doneq.size() != 0 && n < bound) begin
      @(negedge CLOCK);
      n++;
    end
    if (doneq.size() != 0) begin
      check("done_timeout", 1, 0);
      doneq.delete();
    end
    @(negedge CLOCK);
  endtask

  task automatic rd(input int addr, input int expv);
    RD_ADDR = AW'(addr);
    rdq.push_back(expv);
    rd_strobe = 1'b1;
    @(negedge CLOCK);
    rd_strobe = 1'b0;
    @(negedge CLOCK);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge CLOCK);
    RESET_N = 1'b1;
    @(negedge CLOCK);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_error", ERROR, 0);
    check("reset_valid", VALID, 0);
    check("reset_ovf", OVF, 0);
    check("reset_rd_count", RD_COUNT, 0);

    // single channel 3, period 4, window 100; a START mid-run must be ignored
    per[3] = 4;
    repeat (10) @(negedge CLOCK);
    expect_done(103, 0, 4'b1000, 4'b0000);
    start_run(0, 3, 100);
    repeat (49) @(negedge CLOCK);
    check("t1_busy_mid", BUSY, 1);
    MODE = 0; CHANNEL = 0; START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    wait_done(200);
    rd(3, 25);

    // scan, periods 2/4/8/10, window 40
    per = '{2, 4, 8, 10};
    repeat (5) @(negedge CLOCK);
    expect_done(169, 0, 4'b1111, 4'b0000);
    start_run(1, 0, 40);
    wait_done(400);
    rd(0, 20);
    rd(1, 10);
    rd(2, 5);
    rd(3, 4);

    // saturation: 50 edges into a 5-bit counter
    expect_done(103, 0, 4'b1111, 4'b0001);
    start_run(0, 0, 100);
    wait_done(200);
    rd(0, 31);

    // scan with abort in cycle 60 (channel 1 measuring)
    expect_done(0, 0, 0, 0);
    doneq.delete();
    start_run(1, 0, 50);
    repeat (59) @(negedge CLOCK);
    ABORT = 1'b1;
    @(negedge CLOCK);
    ABORT = 1'b0;
    check("t4_busy_after_abort", BUSY, 0);
    repeat (10) @(negedge CLOCK);
    check("t4_valid", VALID, 4'b1101);
    check("t4_ovf", OVF, 4'b0000);
    rd(0, 25);
    rd(1, 10);

    // asynchronous reset in the middle of a measurement
    start_run(0, 2, 100);
    repeat (20) @(negedge CLOCK);
    check("t5_busy_pre_reset", BUSY, 1);
    RESET_N = 1'b0;
    #1;
    check("t5_rst_busy", BUSY, 0);
    check("t5_rst_done", DONE, 0);
    check("t5_rst_error", ERROR, 0);
    check("t5_rst_valid", VALID, 0);
    check("t5_rst_ovf", OVF, 0);
    check("t5_rst_rd_count", RD_COUNT, 0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    per = '{0, 0, 0, 0};
    manual = '0;
    repeat (5) @(negedge CLOCK);
    rd(1, 0);

    // window 0 acts as 1; channel 1 rises so that exactly one edge lands in the single measure cycle
    expect_done(4, 0, 4'b0010, 4'b0000);
    manual[1] = 1'b1;
    start_run(0, 1, 0);
    wait_done(20);
    rd(1, 1);

    // out-of-range channel in single mode
    expect_done(1, 1, 4'b0010, 4'b0000);
    start_run(0, 5, 10);
    check("t6_busy", BUSY, 0);
    wait_done(20);
    check("t6_error_sticky", ERROR, 1);

    // START with ABORT in IDLE is ignored and leaves ERROR set
    MODE = 0; CHANNEL = 0; WINDOW_CYCLES = 5; START = 1'b1; ABORT = 1'b1;
    @(negedge CLOCK);
    START = 1'b0; ABORT = 1'b0;
    check("t7_busy", BUSY, 0);
    check("t7_error_kept", ERROR, 1);
    repeat (12) @(negedge CLOCK);

    // the next accepted START clears ERROR
    expect_done(6, 0, 4'b0011, 4'b0000);
    start_run(0, 0, 3);
    wait_done(20);
    rd(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
